// File: rtl/draw_piece_sprite_if.sv
// ----------------------------------------------------------------------------
// draw_piece_sprite_if
//   Request/plot bundle between the turn manager (master) and the sprite
//   drawer (slave).
//
//   Request side (master -> slave):
//     start        draw request, looked at only while the drawer is idle
//     cx, cy       target board cell column/row (CW bits)
//     shape        0 square, 1 disc, 2 erase, 3 treated as square
//     colour       piece colour
//     hl           highlight request
//   Plot side (slave -> master / VGA adapter write port):
//     plot_x       pixel x (8 b)
//     plot_y       pixel y (7 b)
//     plot_colour  pixel colour
//     plot_en      pixel write strobe
//     busy         drawer is sweeping a sprite
//     done         one-cycle completion pulse
//     err          one-cycle pulse for a start with an off-board cell
// ----------------------------------------------------------------------------
interface draw_piece_sprite_if #(
    parameter int CW    = 3,
    parameter int COL_W = 3
);
    logic             start;
    logic [CW-1:0]    cx;
    logic [CW-1:0]    cy;
    logic [1:0]       shape;
    logic [COL_W-1:0] colour;
    logic             hl;

    logic [7:0]       plot_x;
    logic [6:0]       plot_y;
    logic [COL_W-1:0] plot_colour;
    logic             plot_en;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, cx, cy, shape, colour, hl,
        input  plot_x, plot_y, plot_colour, plot_en, busy, done, err
    );

    modport slave (
        input  start, cx, cy, shape, colour, hl,
        output plot_x, plot_y, plot_colour, plot_en, busy, done, err
    );
endinterface

// File: rtl/draw_piece_sprite.sv
// ----------------------------------------------------------------------------
// draw_piece_sprite
//   Board-cell sprite drawer for the VGA plot path. On an accepted start it
//   sweeps a SIZE x SIZE pixel block of cell (cx,cy), one pixel per clock in
//   row-major order, and emits registered plot strobes. Square, disc (corner
//   cut) and erase (square in BG_COL) modes share the same latency, since
//   masked disc pixels still occupy their cycle.
//
//   Ports:
//     clk     system clock
//     resetn  synchronous reset, active HIGH (name kept from the codebase)
//     bus     draw_piece_sprite_if.slave: request in, plot/status out
//
//   Timing: start sampled at edge 0; pixel k is visited in cycle k+1 and
//   shows on plot_* in cycle k+2; done follows the last strobe by one cycle
//   (start-to-done = SIZE*SIZE + 2).
//
//   Build option: define DRAW_PIECE_HIGHLIGHT_EN to paint the outer ring of
//   a highlighted (hl=1) non-erase sprite in HL_COL. Without it hl is ignored.
//   The port list is the same in both builds.
// ----------------------------------------------------------------------------
module draw_piece_sprite #(
    parameter int              X0      = 10,
    parameter int              Y0      = 27,
    parameter int              PITCH   = 13,
    parameter int              INSET   = 4,
    parameter int              SIZE    = 7,
    parameter int              BOARD_N = 8,
    parameter int              CORNER  = 2,
    parameter int              COL_W   = 3,
    parameter logic [COL_W-1:0] BG_COL = 3'b010,
    parameter logic [COL_W-1:0] HL_COL = 3'b110
) (
    input logic           clk,
    input logic           resetn,
    draw_piece_sprite_if.slave bus
);

    localparam int CW = $clog2(BOARD_N);
    localparam int DW = $clog2(SIZE);

    localparam logic [DW-1:0] LAST   = DW'(SIZE - 1);
    localparam logic [DW:0]   CUT    = (DW+1)'(CORNER);
    localparam logic [CW:0]   NCELLS = (CW+1)'(BOARD_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Latched request: the bus inputs may change freely once accepted.
    typedef struct packed {
        logic [CW-1:0]    cx;
        logic [CW-1:0]    cy;
        logic [1:0]       shape;
        logic [COL_W-1:0] colour;
`ifdef DRAW_PIECE_HIGHLIGHT_EN
        logic             hl;
`endif
    } req_t;

    state_t stateQ, stateNext;
    req_t   reqQ;

    logic [DW-1:0] dx, dy;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic inRange, accept, reject, lastPix;

    always_comb begin
        // Zero-extend by one bit so a power-of-two BOARD_N still compares.
        inRange = ({1'b0, bus.cx} < NCELLS) && ({1'b0, bus.cy} < NCELLS);
        accept  = (stateQ == IDLE) && bus.start && inRange;
        reject  = (stateQ == IDLE) && bus.start && !inRange;
        lastPix = (dx == LAST) && (dy == LAST);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            IDLE:    if (accept)  stateNext = DRAW;
            DRAW:    if (lastPix) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-pixel decode for the pixel (dx,dy) visited this cycle
    // ------------------------------------------------------------------
    logic             isDisc, isErase;
    logic [DW-1:0]    dxRev, dyRev, dxMin, dyMin;
    logic [DW:0]      cornerDist;
    logic             pixEn;
    logic [7:0]       pixX;
    logic [6:0]       pixY;
    logic [COL_W-1:0] pixCol;

    always_comb begin
        isDisc  = (reqQ.shape == 2'd1);
        isErase = (reqQ.shape == 2'd2);

        // Manhattan distance to the nearest sprite corner.
        dxRev      = LAST - dx;
        dyRev      = LAST - dy;
        dxMin      = (dx < dxRev) ? dx : dxRev;
        dyMin      = (dy < dyRev) ? dy : dyRev;
        cornerDist = {1'b0, dxMin} + {1'b0, dyMin};

        pixEn = !(isDisc && (cornerDist < CUT));

        // 8/7-bit arithmetic wraps exactly like truncating the full sum.
        pixX = 8'(X0 + INSET) + 8'(PITCH) * 8'(reqQ.cx) + 8'(dx);
        pixY = 7'(Y0 + INSET) + 7'(PITCH) * 7'(reqQ.cy) + 7'(dy);
    end

`ifdef DRAW_PIECE_HIGHLIGHT_EN
    logic onBorder, nearCut, onRing;

    always_comb begin
        onBorder = (dx == '0) || (dx == LAST) || (dy == '0) || (dy == LAST);
        // Disc pixels sitting right on the edge of a cut corner.
        nearCut  = isDisc && (cornerDist == CUT);
        onRing   = pixEn && (onBorder || nearCut);

        if (isErase) begin
            pixCol = BG_COL;
        end else if (reqQ.hl && onRing) begin
            pixCol = HL_COL;
        end else begin
            pixCol = reqQ.colour;
        end
    end
`else
    always_comb begin
        pixCol = isErase ? BG_COL : reqQ.colour;
    end
`endif

    // ------------------------------------------------------------------
    // Sweep counters, request latch and registered outputs
    // ------------------------------------------------------------------
    logic [7:0]       plotXQ;
    logic [6:0]       plotYQ;
    logic [COL_W-1:0] plotColQ;
    logic             plotEnQ, doneQ, errQ;

    always_ff @(posedge clk) begin
        if (resetn) begin
            reqQ     <= '0;
            dx       <= '0;
            dy       <= '0;
            plotXQ   <= '0;
            plotYQ   <= '0;
            plotColQ <= '0;
            plotEnQ  <= 1'b0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            if (accept) begin
                reqQ.cx     <= bus.cx;
                reqQ.cy     <= bus.cy;
                reqQ.shape  <= bus.shape;
                reqQ.colour <= bus.colour;
`ifdef DRAW_PIECE_HIGHLIGHT_EN
                reqQ.hl     <= bus.hl;
`endif
                dx <= '0;
                dy <= '0;
            end else if (stateQ == DRAW) begin
                if (dx == LAST) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end

            plotEnQ <= (stateQ == DRAW) && pixEn;
            if (stateQ == DRAW) begin
                plotXQ   <= pixX;
                plotYQ   <= pixY;
                plotColQ <= pixCol;
            end

            doneQ <= (stateQ == DONE);
            errQ  <= reject;
        end
    end

    assign bus.plot_x      = plotXQ;
    assign bus.plot_y      = plotYQ;
    assign bus.plot_colour = plotColQ;
    assign bus.plot_en     = plotEnQ;
    assign bus.busy        = (stateQ == DRAW);
    assign bus.done        = doneQ;
    assign bus.err         = errQ;

endmodule

// File: tb/tb_draw_piece_sprite.sv
// ----------------------------------------------------------------------------
// tb_draw_piece_sprite
//   Directed bench. dut uses default parameters; dut2 uses BOARD_N=6 so an
//   off-board index is representable on the 3-bit cell bus.
// ----------------------------------------------------------------------------
module tb_draw_piece_sprite;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    draw_piece_sprite_if #(.CW(3), .COL_W(3)) bus ();
    draw_piece_sprite_if #(.CW(3), .COL_W(3)) bus2 ();

    draw_piece_sprite dut (.clk(clk), .resetn(resetn), .bus(bus));
    draw_piece_sprite #(.BOARD_N(6)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // Per-cycle capture of one draw; index = cycles after the start edge.
    logic       enA   [0:63];
    logic [7:0] xA    [0:63];
    logic [6:0] yA    [0:63];
    logic [2:0] colA  [0:63];
    logic       busyA [0:63];
    logic       doneA [0:63];

    task automatic draw_run(input logic [2:0] x, input logic [2:0] y, input logic [1:0] s,
                            input logic [2:0] c, input logic h, input int restartCyc,
                            input int rstCyc);
        @(negedge clk);
        bus.cx = x; bus.cy = y; bus.shape = s; bus.colour = c; bus.hl = h; bus.start = 1'b1;
        enA[0] = 1'b0; xA[0] = '0; yA[0] = '0; colA[0] = '0; busyA[0] = 1'b0; doneA[0] = 1'b0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            enA[k] = bus.plot_en; xA[k] = bus.plot_x; yA[k] = bus.plot_y;
            colA[k] = bus.plot_colour; busyA[k] = bus.busy; doneA[k] = bus.done;
            // Scramble request inputs: only the latched copy may matter.
            bus.cx = 3'd5; bus.cy = 3'd2; bus.shape = 2'd1; bus.colour = 3'd7; bus.hl = ~h;
            bus.start = (k == restartCyc);
            resetn = (k == rstCyc);
        end
        bus.start = 1'b0;
        resetn = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b1;
        bus.start = 1'b0; bus.cx = '0; bus.cy = '0; bus.shape = '0; bus.colour = '0; bus.hl = 1'b0;
        bus2.start = 1'b0; bus2.cx = '0; bus2.cy = '0; bus2.shape = '0; bus2.colour = '0; bus2.hl = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.plot_x, bus.plot_y, bus.plot_colour} !== 18'd0) begin
            errors++;
            $display("FAIL reset_coords got x=%0d y=%0d c=%0d want 0", bus.plot_x, bus.plot_y, bus.plot_colour);
        end
        checks++;
        if ({bus.plot_en, bus.busy, bus.done, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got en/busy/done/err=%b want 0000",
                     {bus.plot_en, bus.busy, bus.done, bus.err});
        end
        resetn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_square;
        int nEn, nDone, bad;
        draw_run(3'd0, 3'd0, 2'd0, 3'd1, 1'b0, -1, -1);
        nEn = 0; nDone = 0; bad = 0;
        for (int k = 1; k < 64; k++) begin nEn += int'(enA[k]); nDone += int'(doneA[k]); end
        for (int p = 0; p < 49; p++) begin
            if (enA[p+2] !== 1'b1 || xA[p+2] !== 8'(14 + p % 7) || yA[p+2] !== 7'(31 + p / 7)
                || colA[p+2] !== 3'd1) bad++;
        end
        checks++;
        if (nEn !== 49) begin errors++; $display("FAIL sq_count got %0d want 49", nEn); end
        checks++;
        if (enA[1] !== 1'b0 || busyA[1] !== 1'b1) begin
            errors++; $display("FAIL sq_cycle1 got en=%b busy=%b want en=0 busy=1", enA[1], busyA[1]);
        end
        checks++;
        if (xA[2] !== 8'd14 || yA[2] !== 7'd31) begin
            errors++; $display("FAIL sq_first got (%0d,%0d) want (14,31)", xA[2], yA[2]);
        end
        checks++;
        if (xA[50] !== 8'd20 || yA[50] !== 7'd37) begin
            errors++; $display("FAIL sq_last got (%0d,%0d) want (20,37)", xA[50], yA[50]);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL sq_pixels got %0d bad pixels want 0", bad); end
        checks++;
        if (doneA[51] !== 1'b1 || nDone !== 1 || enA[51] !== 1'b0) begin
            errors++; $display("FAIL sq_done got done51=%b count=%0d en51=%b want 1,1,0",
                               doneA[51], nDone, enA[51]);
        end
        checks++;
        if (busyA[49] !== 1'b1 || busyA[50] !== 1'b0) begin
            errors++; $display("FAIL sq_busy got b49=%b b50=%b want 1,0", busyA[49], busyA[50]);
        end
    endtask

    task automatic test_disc;
        int nEn, bad, mx, my, dxv, dyv;
        logic expEn;
        draw_run(3'd7, 3'd7, 2'd1, 3'd4, 1'b0, -1, -1);
        nEn = 0; bad = 0;
        for (int k = 1; k < 64; k++) nEn += int'(enA[k]);
        for (int p = 0; p < 49; p++) begin
            dxv = p % 7; dyv = p / 7;
            mx = (dxv < 6 - dxv) ? dxv : 6 - dxv;
            my = (dyv < 6 - dyv) ? dyv : 6 - dyv;
            expEn = (mx + my >= 2);
            if (enA[p+2] !== expEn) bad++;
            else if (expEn && (xA[p+2] !== 8'(105 + dxv) || yA[p+2] !== 7'(122 + dyv)
                               || colA[p+2] !== 3'd4)) bad++;
        end
        checks++;
        if (nEn !== 37) begin errors++; $display("FAIL disc_count got %0d want 37", nEn); end
        checks++;
        if (enA[2] !== 1'b0 || enA[4] !== 1'b1) begin
            errors++; $display("FAIL disc_corner got en(105,122)=%b en(107,122)=%b want 0,1", enA[2], enA[4]);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL disc_pixels got %0d bad pixels want 0", bad); end
        checks++;
        if (doneA[51] !== 1'b1) begin errors++; $display("FAIL disc_done got %b want 1", doneA[51]); end
    endtask

    task automatic test_erase;
        int nEn, badCol;
        draw_run(3'd3, 3'd4, 2'd2, 3'd5, 1'b1, -1, -1);
        nEn = 0; badCol = 0;
        for (int k = 1; k < 64; k++) begin
            nEn += int'(enA[k]);
            if (enA[k] && colA[k] !== 3'b010) badCol++;
        end
        checks++;
        if (nEn !== 49) begin errors++; $display("FAIL erase_count got %0d want 49", nEn); end
        checks++;
        if (badCol !== 0) begin errors++; $display("FAIL erase_colour got %0d non-BG pixels want 0", badCol); end
        checks++;
        if (xA[2] !== 8'd53 || yA[2] !== 7'd83) begin
            errors++; $display("FAIL erase_first got (%0d,%0d) want (53,83)", xA[2], yA[2]);
        end
    endtask

    task automatic test_start_ignored;
        int nEn, nDone;
        draw_run(3'd0, 3'd0, 2'd0, 3'd1, 1'b0, 10, -1);
        nEn = 0; nDone = 0;
        for (int k = 1; k < 64; k++) begin nEn += int'(enA[k]); nDone += int'(doneA[k]); end
        checks++;
        if (nEn !== 49 || nDone !== 1 || doneA[51] !== 1'b1) begin
            errors++; $display("FAIL ign_draw got en=%0d done=%0d want 49,1", nEn, nDone);
        end
        checks++;
        if (xA[22] !== 8'd20 || yA[22] !== 7'd33) begin
            errors++; $display("FAIL ign_pix20 got (%0d,%0d) want (20,33)", xA[22], yA[22]);
        end
        draw_run(3'd0, 3'd0, 2'd0, 3'd1, 1'b0, 50, -1);
        nEn = 0; nDone = 0;
        for (int k = 1; k < 64; k++) begin nEn += int'(enA[k]); nDone += int'(doneA[k]); end
        checks++;
        if (busyA[52] !== 1'b0 || nEn !== 49 || nDone !== 1) begin
            errors++; $display("FAIL ign_done got busy52=%b en=%0d done=%0d want 0,49,1", busyA[52], nEn, nDone);
        end
    endtask

    task automatic test_reject;
        int nDone;
        @(negedge clk);
        bus2.cx = 3'd6; bus2.cy = 3'd0; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        checks++;
        if (bus2.err !== 1'b1 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL rej_cx got err=%b busy=%b want 1,0", bus2.err, bus2.busy);
        end
        @(negedge clk);
        checks++;
        if (bus2.err !== 1'b0 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL rej_pulse got err=%b busy=%b want 0,0", bus2.err, bus2.busy);
        end
        bus2.cx = 3'd0; bus2.cy = 3'd7; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        checks++;
        if (bus2.err !== 1'b1 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL rej_cy got err=%b busy=%b want 1,0", bus2.err, bus2.busy);
        end
        bus2.cx = 3'd5; bus2.cy = 3'd5; bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        checks++;
        if (bus2.err !== 1'b0 || bus2.busy !== 1'b1) begin
            errors++; $display("FAIL rej_valid got err=%b busy=%b want 0,1", bus2.err, bus2.busy);
        end
        nDone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            nDone += int'(bus2.done);
        end
        checks++;
        if (nDone !== 1) begin errors++; $display("FAIL rej_valid_done got %0d want 1", nDone); end
    endtask

    task automatic test_reset_mid;
        int nEn, nDone;
        draw_run(3'd0, 3'd0, 2'd0, 3'd1, 1'b0, -1, 22);
        nEn = 0; nDone = 0;
        for (int k = 1; k < 64; k++) begin nEn += int'(enA[k]); nDone += int'(doneA[k]); end
        checks++;
        if (enA[22] !== 1'b1 || enA[23] !== 1'b0 || busyA[23] !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort got en22=%b en23=%b busy23=%b want 1,0,0",
                               enA[22], enA[23], busyA[23]);
        end
        checks++;
        if (nEn !== 21 || nDone !== 0) begin
            errors++; $display("FAIL rstmid_counts got en=%0d done=%0d want 21,0", nEn, nDone);
        end
        draw_run(3'd2, 3'd1, 2'd0, 3'd3, 1'b0, -1, -1);
        nEn = 0;
        for (int k = 1; k < 64; k++) nEn += int'(enA[k]);
        checks++;
        if (nEn !== 49 || doneA[51] !== 1'b1 || xA[2] !== 8'd40 || yA[2] !== 7'd44) begin
            errors++; $display("FAIL rstmid_redraw got en=%0d done51=%b first=(%0d,%0d) want 49,1,(40,44)",
                               nEn, doneA[51], xA[2], yA[2]);
        end
    endtask

    task automatic test_highlight;
        int nHl, nNorm;
        draw_run(3'd1, 3'd1, 2'd0, 3'd1, 1'b1, -1, -1);
        nHl = 0; nNorm = 0;
        for (int k = 1; k < 64; k++) begin
            if (enA[k] && colA[k] === 3'b110) nHl++;
            if (enA[k] && colA[k] === 3'd1) nNorm++;
        end
        checks++;
`ifdef DRAW_PIECE_HIGHLIGHT_EN
        if (nHl !== 24 || nNorm !== 25 || colA[2] !== 3'b110 || colA[10] !== 3'd1) begin
            errors++; $display("FAIL hl_ring got hl=%0d norm=%0d want 24,25", nHl, nNorm);
        end
`else
        if (nHl !== 0 || nNorm !== 49) begin
            errors++; $display("FAIL hl_ignored got hl=%0d norm=%0d want 0,49", nHl, nNorm);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_square;
        test_disc;
        test_erase;
        test_start_ignored;
        test_reject;
        test_reset_mid;
        test_highlight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
